// File: rtl/vga_box_motion_ctrl.sv
// vga_box_motion_ctrl: frame-synchronous position update for two boxes via one shared step/wrap unit.
// Coordinates are published atomically on the edge into DONE.
module vga_box_motion_ctrl #(
    parameter int H_ACTIVE  = 1280,
    parameter int V_ACTIVE  = 720,
    parameter int BOX_W     = 64,
    parameter int BOX_H     = 64,
    parameter int SLOW_STEP = 2,
    parameter int FAST_STEP = 6,
    parameter int POS_W     = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             v_sync,
    input  logic [3:0]       key_n,
    input  logic [1:0]       move_en,
    input  logic             sw_fast,
    output logic [POS_W-1:0] xpos_1,
    output logic [POS_W-1:0] ypos_1,
    output logic [POS_W-1:0] xpos_2,
    output logic [POS_W-1:0] ypos_2,
    output logic             busy,
    output logic             frame_done,
    output logic             overrun
);
    typedef enum logic [2:0] {IDLE, LATCH, B1X, B1Y, B2X, B2Y, DONE} state_t;

    localparam logic [POS_W:0] LIM_X = (POS_W+1)'(H_ACTIVE - BOX_W);
    localparam logic [POS_W:0] LIM_Y = (POS_W+1)'(V_ACTIVE - BOX_H);
    localparam logic [POS_W:0] STP_S = (POS_W+1)'(SLOW_STEP);
    localparam logic [POS_W:0] STP_F = (POS_W+1)'(FAST_STEP);
    // Packed order: [0]=x1, [1]=y1, [2]=x2, [3]=y2
    localparam logic [3:0][POS_W-1:0] POS_RST = {POS_W'(V_ACTIVE - BOX_H), POS_W'(H_ACTIVE - BOX_W),
                                                 POS_W'(0), POS_W'(0)};

    state_t state_q, state_d;
    logic [1:0] vs_q;
    logic vs_prev_q;
    logic [3:0] key_s1_q, key_s2_q, dir_q;
    logic [1:0] men_s1_q, men_s2_q, men_q;
    logic fast_s1_q, fast_s2_q, fast_q;
    logic overrun_q, overrun_d;
    logic [3:0][POS_W-1:0] sh_q, sh_d, pos_q, pos_d;
    logic tick, is_x, plus, minus, unit_on;
    logic [1:0] idx;
    logic [POS_W:0] p, s, lim, sum, res;

    assign tick = vs_q[1] & ~vs_prev_q;

    always_comb begin
        idx     = state_q == B1Y ? 2'd1 : state_q == B2X ? 2'd2 : state_q == B2Y ? 2'd3 : 2'd0;
        unit_on = state_q inside {B1X, B1Y, B2X, B2Y};
        is_x    = ~idx[0];
        p       = {1'b0, sh_q[idx]};
        s       = fast_q ? STP_F : STP_S;
        lim     = is_x ? LIM_X : LIM_Y;
        plus    = is_x ? dir_q[0] : dir_q[1];
        minus   = is_x ? dir_q[3] : dir_q[2];
        sum     = p + s;
        res     = (plus & ~minus) ? (sum <= lim ? sum : '0) :
                  (minus & ~plus) ? (p >= s ? p - s : lim) : p;
        sh_d    = state_q == LATCH ? pos_q : sh_q;
        if (unit_on && men_q[idx[1]]) sh_d[idx] = res[POS_W-1:0];
        pos_d     = state_q == B2Y ? sh_d : pos_q;
        overrun_d = overrun_q | (tick & (state_q != IDLE));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = tick ? LATCH : IDLE;
            DONE:    state_d = IDLE;
            default: state_d = state_t'(state_q + 3'd1);
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            vs_q      <= '0;
            vs_prev_q <= 1'b0;
            key_s1_q  <= '1;
            key_s2_q  <= '1;
            men_s1_q  <= '0;
            men_s2_q  <= '0;
            fast_s1_q <= 1'b0;
            fast_s2_q <= 1'b0;
            dir_q     <= '0;
            men_q     <= '0;
            fast_q    <= 1'b0;
            overrun_q <= 1'b0;
            sh_q      <= POS_RST;
            pos_q     <= POS_RST;
        end else begin
            state_q   <= state_d;
            vs_q      <= {vs_q[0], v_sync};
            vs_prev_q <= vs_q[1];
            key_s1_q  <= key_n;
            key_s2_q  <= key_s1_q;
            men_s1_q  <= move_en;
            men_s2_q  <= men_s1_q;
            fast_s1_q <= sw_fast;
            fast_s2_q <= fast_s1_q;
            overrun_q <= overrun_d;
            sh_q      <= sh_d;
            pos_q     <= pos_d;
            if (state_q == LATCH) begin
                dir_q  <= ~key_s2_q;
                men_q  <= men_s2_q;
                fast_q <= fast_s2_q;
            end
        end
    end

    assign xpos_1     = pos_q[0];
    assign ypos_1     = pos_q[1];
    assign xpos_2     = pos_q[2];
    assign ypos_2     = pos_q[3];
    assign busy       = state_q != IDLE;
    assign frame_done = state_q == DONE;
    assign overrun    = overrun_q;
endmodule

// File: doc/vga_box_motion_ctrl.md
Name: vga_box_motion_ctrl

Overview:
- Frame-synchronous motion controller for the two on-screen boxes drawn by the pixel generator.
- Converts each v_sync rising edge into one update frame. Samples the direction keys and switches once per frame.
- Computes new positions for box 1 and box 2 through a single shared step/wrap unit, scheduled over consecutive clk cycles.
- Publishes all four coordinates together, so the pixel generator never sees a half-updated box.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- V_ACTIVE, 720, active lines per frame
- BOX_W, 64, box width in pixels (both boxes)
- BOX_H, 64, box height in lines (both boxes)
- SLOW_STEP, 2, pixels per frame when sw_fast=0
- FAST_STEP, 6, pixels per frame when sw_fast=1
- POS_W, 11, coordinate width

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset, asynchronous, active-low
- v_sync  in  1  vertical sync from the timing generator, active-high
- key_n  in  4  push keys, active-low: [0] right, [3] left, [1] down (+y), [2] up (-y)
- move_en  in  2  per-box move enable: [0] box 1, [1] box 2
- sw_fast  in  1  1 selects FAST_STEP, 0 selects SLOW_STEP
- xpos_1  out  POS_W  box 1 left edge
- ypos_1  out  POS_W  box 1 top edge
- xpos_2  out  POS_W  box 2 left edge
- ypos_2  out  POS_W  box 2 top edge
- busy  out  1  high while an update frame is in progress
- frame_done  out  1  one-cycle pulse when new coordinates are committed
- overrun  out  1  sticky; set when a frame tick arrives while busy

Behaviour:
- Reset (rst=0, asynchronous), all values held until rst deasserts:
  - box 1 = (0, 0); box 2 = (H_ACTIVE-BOX_W, V_ACTIVE-BOX_H)
  - shadow registers equal the outputs
  - state IDLE; busy=0, frame_done=0, overrun=0
- Input sync: v_sync, key_n and move_en each pass through 2 flops; sw_fast passes through 2 flops.
- Frame tick: asserted for one cycle when synced v_sync is 1 and its previous sample was 0.
- State machine, one cycle per state except IDLE:
  - IDLE -> LATCH on tick.
  - LATCH: capture synced keys, move_en, sw_fast into frame registers; load shadows from outputs.
  - B1X -> B1Y -> B2X -> B2Y: each state runs the shared unit on one shadow coordinate. A box with its move_en bit at 0 keeps its shadow unchanged.
  - DONE: copy all four shadows to the outputs in the same edge; frame_done=1 for this cycle -> IDLE.
- busy=1 in LATCH through DONE inclusive.
- Latency: tick in cycle T -> outputs change and frame_done high in cycle T+6.
- Shared unit: s = step; X limit L = H_ACTIVE-BOX_W, Y limit L = V_ACTIVE-BOX_H.
  - + direction only: p+s if p+s <= L, else 0 (wrap).
  - - direction only: p-s if p >= s, else L (wrap).
  - Both directions or neither pressed: p unchanged.
  - Arithmetic is done at POS_W+1 bits so no intermediate overflow occurs.
- Both boxes share the same latched keys. When both move_en bits are set, they move identically in the same frame.
- Tick while busy: the frame is dropped, the sequence in progress is unaffected, overrun is set. overrun is cleared only by reset.
- Input changes after LATCH have no effect until the next frame.
- Outputs never change outside DONE.
- Reset mid-sequence: outputs return to reset values immediately; partially computed shadows are discarded.

Test Plan:
1. Reset, then release rst; no key pressed; 3 v_sync pulses -> outputs stay (0,0) and (1216,656); frame_done pulses 3 times; each pulse 6 cycles after the detected tick.
2. move_en=01, key_n=1110 (right), sw_fast=0, 10 frames -> xpos_1=20, ypos_1=0; box 2 unchanged.
3. move_en=01, xpos_1=1214, right, sw_fast=1 -> xpos_1=0. Then left from 4 with sw_fast=1 -> xpos_1=1216.
4. move_en=11, key_n=1101 (down), sw_fast=0, one frame -> ypos_1=2, ypos_2=0 (656+2>656 wraps). Both updated in the same frame_done cycle.
5. key_n=0110 (left+right) -> x coordinates unchanged. Key changed during busy -> ignored until the next frame.
6. Second v_sync edge during busy -> overrun=1, exactly one frame_done. Pull rst low during B2X -> outputs go to reset values immediately; busy=0 and overrun=0.
